// File: rtl/menu_controller.sv
// menu_controller: debounces the board push-buttons, moves the menu cursor
// and launches or tears down games for the menu renderer and game cores.
//
// Ports:
//   CLOCK_50     system clock (posedge)
//   reset_n      async active-low reset
//   btn_up       raw button, active-high, asynchronous
//   btn_down     raw button, active-high, asynchronous
//   btn_select   raw button, active-high, asynchronous
//   btn_back     raw button, active-high, asynchronous
//   game_over    level from the running game, honoured only in PLAY
//   m            menu visible (state MENU)
//   cursor       highlighted item, 0..NUM_ITEMS-1
//   game_id      launched game index, latched on select
//   game_start   one-cycle launch pulse
//   game_active  high in state PLAY
module menu_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_ITEMS       = 4,
    parameter int NUM_GAMES       = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_select,
    input  logic       btn_back,
    input  logic       game_over,
    output logic       m,
    output logic [1:0] cursor,
    output logic [1:0] game_id,
    output logic       game_start,
    output logic       game_active
);

    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]    LAST    = 2'(NUM_ITEMS - 1);
    localparam logic [2:0]    GAMES   = 3'(NUM_GAMES);

    typedef enum logic [1:0] {
        MENU,
        LAUNCH,
        PLAY
    } state_t;

    // channel order: 0=up 1=down 2=select 3=back
    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    stable_prev;
    logic [3:0]    ev;
    logic [CW-1:0] cnt [4];

    assign raw = {btn_back, btn_select, btn_down, btn_up};

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            stable      <= '0;
            stable_prev <= '0;
            ev          <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= raw;
            sync2       <= sync1;
            stable_prev <= stable;
            ev          <= stable & ~stable_prev;
            for (int i = 0; i < 4; i++) begin
                // a level must disagree with stable for
                // DEBOUNCE_CYCLES samples in a row to be accepted
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic ev_up;
    logic ev_down;
    logic ev_sel;
    logic ev_back;

    assign ev_up   = ev[0];
    assign ev_down = ev[1];
    assign ev_sel  = ev[2];
    assign ev_back = ev[3];

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cursor_d;
    logic [1:0] game_id_d;
    logic       m_d;
    logic       start_d;
    logic       active_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= MENU;
            cursor      <= 2'd0;
            game_id     <= 2'd0;
            m           <= 1'b1;
            game_start  <= 1'b0;
            game_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor      <= cursor_d;
            game_id     <= game_id_d;
            m           <= m_d;
            game_start  <= start_d;
            game_active <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor;
        game_id_d = game_id;
        unique case (state_q)
            MENU: begin
                // select wins over any same-cycle cursor move
                if (ev_sel) begin
                    if ({1'b0, cursor} < GAMES) begin
                        game_id_d = cursor;
                        state_d   = LAUNCH;
                    end
                end else if (ev_up && !ev_down) begin
                    cursor_d = (cursor == 2'd0) ? LAST : cursor - 2'd1;
                end else if (ev_down && !ev_up) begin
                    cursor_d = (cursor == LAST) ? 2'd0 : cursor + 2'd1;
                end
            end
            LAUNCH: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (ev_back || game_over) begin
                    state_d = MENU;
                end
            end
            default: begin
                state_d = MENU;
            end
        endcase
    end

    // outputs decode the next state so they move with the state
    always_comb begin
        m_d      = 1'b0;
        start_d  = 1'b0;
        active_d = 1'b0;
        unique case (state_d)
            MENU:    m_d      = 1'b1;
            LAUNCH:  start_d  = 1'b1;
            PLAY:    active_d = 1'b1;
            default: m_d      = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed bench for menu_controller
// with DEBOUNCE_CYCLES=4, NUM_ITEMS=4, NUM_GAMES=2.
module tb_menu_controller;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [3:0] btn;
    logic       game_over;
    logic       m;
    logic [1:0] cursor;
    logic [1:0] game_id;
    logic       game_start;
    logic       game_active;

    int n_chk  = 0;
    int n_pass = 0;
    int starts = 0;
    int s0;
    bit ok;

    always #5 CLOCK_50 = ~CLOCK_50;

    menu_controller #(
        .DEBOUNCE_CYCLES(4),
        .NUM_ITEMS(4),
        .NUM_GAMES(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n(reset_n),
        .btn_up(btn[0]),
        .btn_down(btn[1]),
        .btn_select(btn[2]),
        .btn_back(btn[3]),
        .game_over(game_over),
        .m(m),
        .cursor(cursor),
        .game_id(game_id),
        .game_start(game_start),
        .game_active(game_active)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (game_start === 1'b1) starts++;
    endtask

    task automatic press(input logic [3:0] b, input int hold);
        btn = b;
        repeat (hold) tick();
        btn = '0;
        repeat (14) tick();
    endtask

    // {m, cursor, game_start, game_active}
    function automatic logic [4:0] outs();
        return {m, cursor, game_start, game_active};
    endfunction

    initial begin
        reset_n   = 1'b0;
        btn       = '0;
        game_over = 1'b0;
        repeat (3) tick();
        chk("reset_outs", {outs(), game_id}, {5'b1_00_00, 2'd0});
        reset_n = 1'b1;

        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle", outs(), 5'b1_00_00);
        end

        // held down: acts exactly on edge 8
        btn = 4'b0010;
        ok  = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (cursor !== 2'd0) ok = 1'b0;
        end
        chk("down_early", {31'd0, ok}, 32'd1);
        tick();
        chk("down_edge8", cursor, 2'd1);
        repeat (2) tick();
        btn = '0;
        repeat (14) tick();
        chk("down_norepeat", cursor, 2'd1);

        press(4'b0010, 10);
        chk("down_2", cursor, 2'd2);
        press(4'b0010, 10);
        chk("down_3", cursor, 2'd3);
        press(4'b0010, 10);
        chk("down_wrap", cursor, 2'd0);
        press(4'b0001, 10);
        chk("up_wrap", cursor, 2'd3);

        press(4'b0001, 3);
        chk("glitch", cursor, 2'd3);
        press(4'b0011, 10);
        chk("up_down", cursor, 2'd3);

        press(4'b0010, 10);
        press(4'b0010, 10);
        chk("to_1", cursor, 2'd1);

        // launch from cursor 1
        btn = 4'b0100;
        repeat (7) tick();
        chk("pre_launch", outs(), 5'b1_01_00);
        tick();
        chk("launch", outs(), 5'b0_01_10);
        chk("launch_id", game_id, 2'd1);
        tick();
        chk("play", outs(), 5'b0_01_01);
        tick();
        btn = '0;
        repeat (14) tick();
        chk("one_start", starts, 1);

        press(4'b0001, 10);
        press(4'b0010, 10);
        chk("play_ignore", outs(), 5'b0_01_01);

        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        chk("game_over", {outs(), game_id}, {5'b1_01_00, 2'd1});

        press(4'b0100, 10);
        chk("relaunch", outs(), 5'b0_01_01);
        chk("two_starts", starts, 2);
        press(4'b1000, 10);
        chk("back", {outs(), game_id}, {5'b1_01_00, 2'd1});

        press(4'b0001, 10);
        press(4'b0001, 10);
        chk("to_3", cursor, 2'd3);
        s0 = starts;
        press(4'b0100, 10);
        chk("inert_start", starts, s0);
        chk("inert_menu", outs(), 5'b1_11_00);

        // reset while in LAUNCH
        press(4'b0010, 10);
        chk("to_0", cursor, 2'd0);
        btn = 4'b0100;
        repeat (8) tick();
        chk("launch0", outs(), 5'b0_00_10);
        reset_n = 1'b0;
        #1;
        chk("rst_launch", {outs(), game_id}, {5'b1_00_00, 2'd0});
        btn = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        s0 = starts;
        repeat (20) tick();
        chk("rst_nostart", starts, s0);
        chk("rst_menu", {outs(), game_id}, {5'b1_00_00, 2'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
